// File: rtl/owl_txn_arb.sv
// Round-robin transaction scheduler in front of the one-wire master frame engine.
// Define OWL_ARB_RETRY_EN to re-issue failed frames up to MAX_RETRY times.
module owl_txn_arb #(
    parameter int                  NREQ      = 4,
    parameter int                  IDX_W     = 2,
    parameter int                  TO_WIDTH  = 16,
    parameter logic [TO_WIDTH-1:0] TO_CYC    = 16'hC000,
    parameter logic [7:0]          GAP_CYC   = 8'h40,
    parameter int                  MAX_RETRY = 2
) (
    input  logic                rst,
    input  logic                clk,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     req_cmd,
    input  logic [NREQ*7-1:0]   req_addr,
    input  logic [NREQ*8-1:0]   req_num,
    input  logic [NREQ*24-1:0]  req_wdata,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     done,
    output logic [7:0]          rsp_status,
    output logic [1:0]          rsp_err,
    output logic                busy,
    output logic                m_start,
    output logic                m_cmd,
    output logic [6:0]          m_addr,
    output logic [7:0]          m_num,
    output logic [7:0]          m_wdata0,
    output logic [7:0]          m_wdata1,
    output logic [7:0]          m_wdata2,
`ifdef OWL_ARB_RETRY_EN
    output logic [1:0]          rsp_retries,
`endif
    input  logic                m_done,
    input  logic [7:0]          m_status,
    input  logic                m_err
);

    typedef enum logic [2:0] {S_IDLE, S_ARB, S_ISSUE, S_WAIT, S_GAP, S_DONE} state_t;

`ifdef OWL_ARB_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif
    localparam logic [1:0]          RETRY_LIM = 2'(MAX_RETRY);
    localparam logic [TO_WIDTH-1:0] TO_LAST   = TO_CYC - TO_WIDTH'(1);
    // A zero gap still occupies one GAP cycle.
    localparam logic [7:0]          GAP_LAST  = (GAP_CYC == 8'd0) ? 8'd0 : GAP_CYC - 8'd1;

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    rr_ptr, win_idx, arb_idx;
    logic [TO_WIDTH-1:0] to_cnt;
    logic [7:0]          gap_cnt;
    logic [1:0]          retry_cnt;
    logic                retry_pend;
    logic                any_req, wait_ok, wait_to, gap_end, fail, retry_go;

    logic [6:0]  addr_a  [NREQ];
    logic [7:0]  num_a   [NREQ];
    logic [23:0] wdata_a [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign addr_a[i]  = req_addr[7*i +: 7];
        assign num_a[i]   = req_num[8*i +: 8];
        assign wdata_a[i] = req_wdata[24*i +: 24];
    end

    // First asserted request after ptr, wrapping; the lowest offset wins.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0] r,
                                                 input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] sel, j;
        sel = ptr;
        for (int k = NREQ; k >= 1; k--) begin
            j = IDX_W'((int'(ptr) + k) % NREQ);
            if (r[j]) sel = j;
        end
        return sel;
    endfunction

    assign any_req  = |req;
    assign arb_idx  = rr_pick(req, rr_ptr);
    assign wait_ok  = (state == S_WAIT) && m_done;
    assign wait_to  = (state == S_WAIT) && !m_done && (to_cnt == TO_LAST);
    assign gap_end  = (state == S_GAP) && (gap_cnt == GAP_LAST);
    assign fail     = (wait_ok && m_err) || wait_to;
    assign retry_go = RETRY_EN && fail && (retry_cnt < RETRY_LIM);
    assign busy     = (state != S_IDLE);

`ifdef OWL_ARB_RETRY_EN
    assign rsp_retries = retry_cnt;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        gnt       = '0;
        done      = '0;
        m_start   = 1'b0;
        case (state)
            S_IDLE:  if (any_req) state_nxt = S_ARB;
            S_ARB: begin
                if (any_req) begin
                    gnt       = NREQ'(1) << arb_idx;
                    state_nxt = S_ISSUE;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_ISSUE: begin
                m_start   = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT:  if (wait_ok || wait_to) state_nxt = S_GAP;
            S_GAP:   if (gap_end) state_nxt = retry_pend ? S_ISSUE : S_DONE;
            S_DONE: begin
                done      = NREQ'(1) << win_idx;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr     <= IDX_W'(NREQ - 1);
            win_idx    <= '0;
            m_cmd      <= 1'b0;
            m_addr     <= '0;
            m_num      <= '0;
            m_wdata0   <= '0;
            m_wdata1   <= '0;
            m_wdata2   <= '0;
            rsp_status <= '0;
            rsp_err    <= '0;
            to_cnt     <= '0;
            gap_cnt    <= '0;
            retry_cnt  <= '0;
            retry_pend <= 1'b0;
        end else begin
            // Winner fields are frozen here and held until the next arbitration.
            if (state == S_ARB && any_req) begin
                rr_ptr    <= arb_idx;
                win_idx   <= arb_idx;
                m_cmd     <= req_cmd[arb_idx];
                m_addr    <= addr_a[arb_idx];
                m_num     <= num_a[arb_idx];
                m_wdata0  <= wdata_a[arb_idx][7:0];
                m_wdata1  <= wdata_a[arb_idx][15:8];
                m_wdata2  <= wdata_a[arb_idx][23:16];
                retry_cnt <= '0;
            end

            if (state == S_ISSUE)     to_cnt <= '0;
            else if (state == S_WAIT) to_cnt <= to_cnt + 1'b1;

            // m_done has priority over a timeout landing in the same cycle.
            if (wait_ok) begin
                rsp_status <= m_status;
                rsp_err    <= m_err ? 2'b01 : 2'b00;
            end else if (wait_to) begin
                rsp_status <= 8'hFF;
                rsp_err    <= 2'b10;
            end

            if (state != S_GAP) gap_cnt <= '0;
            else                gap_cnt <= gap_cnt + 1'b1;

            if (retry_go) begin
                retry_cnt  <= retry_cnt + 1'b1;
                retry_pend <= 1'b1;
            end else if (gap_end) begin
                retry_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_owl_txn_arb.sv
// Randomized directed bench for owl_txn_arb; a responder stands in for the master,
// and a transaction-level model predicts winners, latencies and status.
module tb_owl_txn_arb;

    localparam int         NREQ      = 4;
    localparam int         TO_I      = 300;
    localparam logic [7:0] GAP_CYC   = 8'd8;
    localparam int         GAP_EFF   = 8;
    localparam int         MAX_RETRY = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req = '0;
    logic [3:0]  req_cmd = '0;
    logic [27:0] req_addr = '0;
    logic [31:0] req_num = '0;
    logic [95:0] req_wdata = '0;
    logic [3:0]  gnt, done;
    logic [7:0]  rsp_status;
    logic [1:0]  rsp_err;
    logic        busy, m_start, m_cmd;
    logic [6:0]  m_addr;
    logic [7:0]  m_num, m_wdata0, m_wdata1, m_wdata2;
    logic        m_done = 1'b0;
    logic [7:0]  m_status = '0;
    logic        m_err = 1'b0;

    logic [3:0]  req_z = '0;
    logic [3:0]  gnt_z, done_z;
    logic [7:0]  rsp_status_z;
    logic [1:0]  rsp_err_z;
    logic        busy_z, m_start_z, m_cmd_z;
    logic [6:0]  m_addr_z;
    logic [7:0]  m_num_z, m_wdata0_z, m_wdata1_z, m_wdata2_z;
    logic        m_done_z = 1'b0;
    logic [7:0]  m_status_z = '0;
    logic        m_err_z = 1'b0;
`ifdef OWL_ARB_RETRY_EN
    logic [1:0]  rsp_retries, rsp_retries_z;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rr_model = NREQ - 1;

    int         pend = 0;
    int         resp_delay = 0;
    logic [7:0] resp_status = '0;
    logic       resp_err = 1'b0;

    owl_txn_arb #(.NREQ(4), .IDX_W(2), .TO_WIDTH(16), .TO_CYC(16'(TO_I)),
                  .GAP_CYC(GAP_CYC), .MAX_RETRY(MAX_RETRY)) dut (
        .rst(rst), .clk(clk), .req(req), .req_cmd(req_cmd), .req_addr(req_addr),
        .req_num(req_num), .req_wdata(req_wdata), .gnt(gnt), .done(done),
        .rsp_status(rsp_status), .rsp_err(rsp_err), .busy(busy), .m_start(m_start),
        .m_cmd(m_cmd), .m_addr(m_addr), .m_num(m_num), .m_wdata0(m_wdata0),
        .m_wdata1(m_wdata1), .m_wdata2(m_wdata2),
`ifdef OWL_ARB_RETRY_EN
        .rsp_retries(rsp_retries),
`endif
        .m_done(m_done), .m_status(m_status), .m_err(m_err));

    owl_txn_arb #(.NREQ(4), .IDX_W(2), .TO_WIDTH(16), .TO_CYC(16'(TO_I)),
                  .GAP_CYC(8'd0), .MAX_RETRY(MAX_RETRY)) dut_z (
        .rst(rst), .clk(clk), .req(req_z), .req_cmd(req_cmd), .req_addr(req_addr),
        .req_num(req_num), .req_wdata(req_wdata), .gnt(gnt_z), .done(done_z),
        .rsp_status(rsp_status_z), .rsp_err(rsp_err_z), .busy(busy_z), .m_start(m_start_z),
        .m_cmd(m_cmd_z), .m_addr(m_addr_z), .m_num(m_num_z), .m_wdata0(m_wdata0_z),
        .m_wdata1(m_wdata1_z), .m_wdata2(m_wdata2_z),
`ifdef OWL_ARB_RETRY_EN
        .rsp_retries(rsp_retries_z),
`endif
        .m_done(m_done_z), .m_status(m_status_z), .m_err(m_err_z));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Master stand-in: m_done is raised resp_delay cycles after each m_start (0 = never).
    always @(negedge clk) begin
        m_done = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                m_done   = 1'b1;
                m_status = resp_status;
                m_err    = resp_err;
            end
        end
        if (m_start) pend = resp_delay;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first requester after the last winner, wrapping.
    function automatic int model_pick(input logic [3:0] r, input int p);
        for (int k = 1; k <= NREQ; k++)
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    task automatic scramble_fields;
        for (int i = 0; i < NREQ; i++) begin
            req_cmd[i]           = 1'($urandom);
            req_addr[7*i +: 7]   = 7'($urandom);
            req_num[8*i +: 8]    = 8'($urandom);
            req_wdata[24*i +: 24] = 24'($urandom);
        end
    endtask

    task automatic run_txn(input logic [3:0] rq, input int d, input logic [7:0] st,
                           input logic er, input bit hold);
        int w, t0, s, starts, extra, n_att, len, period, bud;
        logic [15:0] e_hdr;
        logic [23:0] e_wd;
        bit ok_path;
        scramble_fields();
        resp_delay  = d;
        resp_status = st;
        resp_err    = er;
        w     = model_pick(rq, rr_model);
        e_hdr = {req_cmd[w], req_addr[7*w +: 7], req_num[8*w +: 8]};
        e_wd  = req_wdata[24*w +: 24];
        req   = rq;
        t0    = cyc;
        step();
        for (int k = 0; k < 8 && gnt == 4'd0; k++) step();
        chk("gnt_latency", 32'(cyc - t0), 32'd1);
        chk("gnt_winner", 32'(gnt), 32'(1) << w);
        step();
        s = cyc;
        chk("m_start", 32'(m_start), 32'd1);
        chk("m_hdr", 32'({m_cmd, m_addr, m_num}), 32'(e_hdr));
        chk("m_wdata", 32'({m_wdata2, m_wdata1, m_wdata0}), 32'(e_wd));
        if (!hold) req[w] = 1'b0;
        scramble_fields();
        ok_path = (d > 0) && (d <= TO_I);
        len     = ok_path ? d : TO_I;
        n_att   = 1;
`ifdef OWL_ARB_RETRY_EN
        if (!ok_path || er) n_att = MAX_RETRY + 1;
`endif
        period = len + GAP_EFF + 1;
        bud    = n_att * period + 20;
        starts = 1;
        extra  = 0;
        while (done == 4'd0 && (cyc - s) < bud) begin
            step();
            if (m_start) starts++;
            if (gnt != 4'd0) extra++;
        end
        chk("done_latency", 32'(cyc - s), 32'(n_att * period));
        chk("done_owner", 32'(done), 32'(1) << w);
        chk("rsp_status", 32'(rsp_status), ok_path ? 32'(st) : 32'hFF);
        chk("rsp_err", 32'(rsp_err), ok_path ? (er ? 32'd1 : 32'd0) : 32'd2);
        chk("start_count", 32'(starts), 32'(n_att));
        chk("gnt_in_flight", 32'(extra), 32'd0);
        chk("fields_held", 32'({m_cmd, m_addr, m_num}), 32'(e_hdr));
        chk("wdata_held", 32'({m_wdata2, m_wdata1, m_wdata0}), 32'(e_wd));
`ifdef OWL_ARB_RETRY_EN
        chk("rsp_retries", 32'(rsp_retries), 32'(n_att - 1));
`endif
        step();
        chk("idle_after_done", 32'({busy, done}), 32'd0);
        rr_model = w;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_gnt_done"}, 32'({gnt, done}), 32'd0);
        chk({tag, "_busy_start"}, 32'({busy, m_start}), 32'd0);
        chk({tag, "_fields"}, 32'({m_cmd, m_addr, m_num}), 32'd0);
        chk({tag, "_wdata"}, 32'({m_wdata2, m_wdata1, m_wdata0}), 32'd0);
        chk({tag, "_rsp"}, 32'({rsp_status, rsp_err}), 32'd0);
    endtask

    initial begin
        logic [3:0] rq;
        req = 4'hF;
        repeat (3) step();
        chk_reset_outputs("reset");
        req = 4'h0;
        rst = 1'b1;
        step();

        // Continuous requests from everyone rotate 0,1,2,3,0.
        for (int i = 0; i < 5; i++) run_txn(4'b1111, 20, 8'(8'h10 + i), 1'b0, 1'b1);
        req = 4'h0;
        step();

        // Request withdrawn during ARB: no grant, pointer untouched.
        req = 4'b0010;
        step();
        chk("arb_gnt_live", 32'(gnt), 32'b0010);
        req = 4'b0000;
        #1;
        chk("arb_gnt_drop", 32'(gnt), 32'd0);
        step();
        chk("arb_back_idle", 32'({busy, m_start}), 32'd0);
        run_txn(4'b0011, 30, 8'hA5, 1'b0, 1'b0);

        run_txn(4'b0001, 100, 8'h00, 1'b0, 1'b0);
        run_txn(4'b0010, 0, 8'h00, 1'b0, 1'b0);
        run_txn(4'b1000, TO_I, 8'h77, 1'b0, 1'b0);
        run_txn(4'b0100, TO_I + 1, 8'h66, 1'b0, 1'b0);
        run_txn(4'b0100, 50, 8'h5A, 1'b1, 1'b0);
        run_txn(4'b1001, 5, 8'hC3, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            rq = 4'($urandom_range(1, 15));
            run_txn(rq, $urandom_range(1, 40), 8'($urandom),
                    1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
        end
        req = 4'h0;
        step();

        // Reset in the middle of a frame.
        resp_delay = 0;
        req = 4'b0010;
        step();
        step();
        req = 4'b0000;
        repeat (5) step();
        chk("wait_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        repeat (3) step();
        chk("midrst_hold", 32'({busy, m_start, gnt}), 32'd0);
        rst = 1'b1;
        rr_model = NREQ - 1;
        run_txn(4'b0100, 10, 8'h11, 1'b0, 1'b0);

        // Zero-gap instance: done two cycles after m_done.
        req_z = 4'b0001;
        step();
        chk("z_gnt", 32'(gnt_z), 32'b0001);
        step();
        chk("z_start", 32'(m_start_z), 32'd1);
        chk("z_hdr", 32'({m_cmd_z, m_addr_z, m_num_z}),
            32'({req_cmd[0], req_addr[6:0], req_num[7:0]}));
        chk("z_wdata", 32'({m_wdata2_z, m_wdata1_z, m_wdata0_z}), 32'(req_wdata[23:0]));
        req_z = 4'b0000;
        step();
        step();
        m_status_z = 8'h3C;
        m_err_z    = 1'b0;
        m_done_z   = 1'b1;
        step();
        m_done_z   = 1'b0;
        chk("z_gap", 32'({busy_z, done_z}), 32'b10000);
        step();
        chk("z_done", 32'(done_z), 32'b0001);
        chk("z_rsp", 32'({rsp_status_z, rsp_err_z}), 32'({8'h3C, 2'b00}));
`ifdef OWL_ARB_RETRY_EN
        chk("z_retries", 32'(rsp_retries_z), 32'd0);
`endif
        step();
        chk("z_idle", 32'(busy_z), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
